// File: rtl/gray_pkg.sv
// Shared constants and Gray/binary conversion helpers for the async FIFO pointer logic.
// Helpers work on 32-bit values; callers cast to their pointer width.
package gray_pkg;

  localparam int unsigned MODE_WR = 0;
  localparam int unsigned MODE_RD = 1;

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  // Bit i of the result is the XOR of g[31:i].
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b = g;
    for (int i = 1; i < 32; i++) begin
      b = b ^ (g >> i);
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_to_bin_converter.sv
// Combinational Gray-to-binary conversion of an N+1 bit pointer.
module gray_to_bin_converter
  import gray_pkg::*;
#(
  parameter int unsigned N = 3
) (
  input  logic [N:0] gray,
  output logic [N:0] bin
);

  assign bin = (N + 1)'(gray2bin(32'(gray)));

endmodule

// File: rtl/gray_fifo_ptr_ctrl.sv
// One side of an async FIFO: binary/Gray pointer, far-side pointer synchroniser,
// full (write side) or empty (read side) flag, almost flag and fill level.
module gray_fifo_ptr_ctrl
  import gray_pkg::*;
#(
  parameter int unsigned ADDR_W      = 3,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned MODE        = 0,
  parameter int unsigned ALMOST_THR  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              inc,
  input  logic [ADDR_W:0]   rmt_gray_ptr,
  output logic              acc,
  output logic [ADDR_W-1:0] addr,
  output logic [ADDR_W:0]   bin_ptr,
  output logic [ADDR_W:0]   gray_ptr,
  output logic              flag,
  output logic              almost,
  output logic [ADDR_W:0]   level
);

  localparam int unsigned PW    = ADDR_W + 1;
  localparam int unsigned DEPTH = 2 ** ADDR_W;

  localparam logic [ADDR_W:0] AlmFullLvl = PW'(DEPTH - ALMOST_THR);
  localparam logic [ADDR_W:0] AlmEmptyLvl = PW'(ALMOST_THR);
  // Full when the two MSBs differ from the remote pointer and the rest match.
  localparam logic [ADDR_W:0] FullMask = PW'(3) << (ADDR_W - 1);
  localparam logic RstFlag = (MODE == MODE_RD);
  localparam logic RstAlmost = (MODE == MODE_RD) || (DEPTH <= ALMOST_THR);

  logic [ADDR_W:0] sync_q [SYNC_STAGES];
  logic [ADDR_W:0] rsync;
  logic [ADDR_W:0] rmt_bin;
  logic [ADDR_W:0] bin_nxt;
  logic [ADDR_W:0] gray_nxt;
  logic [ADDR_W:0] lvl_nxt;
  logic            flag_nxt;
  logic            almost_nxt;
  logic            clr;

  assign clr   = !rst_n || flush;
  assign rsync = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= rmt_gray_ptr;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  gray_to_bin_converter #(
    .N (ADDR_W)
  ) u_rmt_conv (
    .gray (rsync),
    .bin  (rmt_bin)
  );

  assign acc      = inc & ~flag;
  assign addr     = bin_ptr[ADDR_W-1:0];
  assign bin_nxt  = bin_ptr + PW'(acc);
  assign gray_nxt = PW'(bin2gray(32'(bin_nxt)));

  // Flags use the new local pointer against the old synchronised remote pointer.
  always_comb begin
    lvl_nxt    = '0;
    flag_nxt   = 1'b0;
    almost_nxt = 1'b0;
    if (MODE == MODE_WR) begin
      lvl_nxt    = bin_nxt - rmt_bin;
      flag_nxt   = (gray_nxt == (rsync ^ FullMask));
      almost_nxt = (lvl_nxt >= AlmFullLvl);
    end else begin
      lvl_nxt    = rmt_bin - bin_nxt;
      flag_nxt   = (gray_nxt == rsync);
      almost_nxt = (lvl_nxt <= AlmEmptyLvl);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bin_ptr  <= '0;
      gray_ptr <= '0;
      flag     <= RstFlag;
      almost   <= RstAlmost;
      level    <= '0;
    end else if (flush) begin
      bin_ptr  <= '0;
      gray_ptr <= '0;
      flag     <= RstFlag;
      almost   <= RstAlmost;
      level    <= '0;
    end else begin
      bin_ptr  <= bin_nxt;
      gray_ptr <= gray_nxt;
      flag     <= flag_nxt;
      almost   <= almost_nxt;
      level    <= lvl_nxt;
    end
  end

endmodule

// File: tb/tb_gray_fifo_ptr_ctrl.sv
// Bench for a write-side/read-side pair of gray_fifo_ptr_ctrl, optionally looped back.
// Expectations are queued by the stimulus and checked by a negedge monitor.
module tb_gray_fifo_ptr_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       flush;
  logic       loop_en;
  logic [1:0] inc;
  logic [3:0] wr_rmt_drv;
  logic [3:0] rd_rmt_drv;

  logic       w_acc, w_flag, w_alm, r_acc, r_flag, r_alm;
  logic [2:0] w_addr, r_addr;
  logic [3:0] w_bin, w_gray, w_lvl, r_bin, r_gray, r_lvl;
  logic [3:0] w_rmt, r_rmt;
  logic [3:0] prev_w_gray, prev_r_gray;

  always #5 clk = ~clk;

  assign w_rmt = loop_en ? r_gray : wr_rmt_drv;
  assign r_rmt = loop_en ? w_gray : rd_rmt_drv;

  gray_fifo_ptr_ctrl #(
    .ADDR_W(3), .SYNC_STAGES(2), .MODE(0), .ALMOST_THR(2)
  ) u_wr (
    .clk(clk), .rst_n(rst_n), .flush(flush), .inc(inc[0]), .rmt_gray_ptr(w_rmt),
    .acc(w_acc), .addr(w_addr), .bin_ptr(w_bin), .gray_ptr(w_gray), .flag(w_flag),
    .almost(w_alm), .level(w_lvl)
  );

  gray_fifo_ptr_ctrl #(
    .ADDR_W(3), .SYNC_STAGES(2), .MODE(1), .ALMOST_THR(2)
  ) u_rd (
    .clk(clk), .rst_n(rst_n), .flush(flush), .inc(inc[1]), .rmt_gray_ptr(r_rmt),
    .acc(r_acc), .addr(r_addr), .bin_ptr(r_bin), .gray_ptr(r_gray), .flag(r_flag),
    .almost(r_alm), .level(r_lvl)
  );

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] exp;
  } chk_t;

  chk_t sbq[$];
  int   n_pass = 0;
  int   n_total = 0;

  // Selector: side*8 + field (acc, addr, bin, gray, flag, almost, level, gray bits changed).
  function automatic logic [31:0] actual(input int sel);
    case (sel)
      0:  return 32'(w_acc);
      1:  return 32'(w_addr);
      2:  return 32'(w_bin);
      3:  return 32'(w_gray);
      4:  return 32'(w_flag);
      5:  return 32'(w_alm);
      6:  return 32'(w_lvl);
      7:  return 32'($countones(w_gray ^ prev_w_gray));
      8:  return 32'(r_acc);
      9:  return 32'(r_addr);
      10: return 32'(r_bin);
      11: return 32'(r_gray);
      12: return 32'(r_flag);
      13: return 32'(r_alm);
      14: return 32'(r_lvl);
      15: return 32'($countones(r_gray ^ prev_r_gray));
      default: return 32'hdead_beef;
    endcase
  endfunction

  always @(negedge clk) begin
    chk_t        c;
    logic [31:0] a;
    while (sbq.size() > 0) begin
      c = sbq.pop_front();
      a = actual(c.sel);
      n_total++;
      if (a === c.exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", c.name, a, c.exp);
    end
    prev_w_gray <= w_gray;
    prev_r_gray <= r_gray;
  end

  task automatic push_exp(input string nm, input int sel, input logic [31:0] v);
    chk_t c;
    c.name = nm;
    c.sel  = sel;
    c.exp  = v;
    sbq.push_back(c);
  endtask

  // Reference model, formulated on binary occupancy rather than Gray compares.
  logic [3:0] m_bin[2], m_s0[2], m_s1[2], m_lvl[2];
  logic       m_flag[2], m_alm[2], m_adv[2];

  function automatic logic [3:0] b2g(input logic [3:0] b);
    return b ^ {1'b0, b[3:1]};
  endfunction

  function automatic logic [3:0] g2b(input logic [3:0] g);
    logic [3:0] b;
    b[3] = g[3];
    for (int i = 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  task automatic cycle(input bit chk, input bit step);
    logic [3:0] n_bin[2], n_s0[2], n_s1[2], n_lvl[2], rmt[2];
    logic [3:0] rb;
    logic       n_flag[2], n_alm[2], a[2];
    string      sn;
    rmt[0] = loop_en ? b2g(m_bin[1]) : wr_rmt_drv;
    rmt[1] = loop_en ? b2g(m_bin[0]) : rd_rmt_drv;
    for (int s = 0; s < 2; s++) begin
      sn   = (s == 0) ? "wr" : "rd";
      a[s] = inc[s] & ~m_flag[s];
      if (chk) begin
        push_exp({sn, "_acc"},    s * 8 + 0, 32'(a[s]));
        push_exp({sn, "_addr"},   s * 8 + 1, 32'(m_bin[s][2:0]));
        push_exp({sn, "_bin"},    s * 8 + 2, 32'(m_bin[s]));
        push_exp({sn, "_gray"},   s * 8 + 3, 32'(b2g(m_bin[s])));
        push_exp({sn, "_flag"},   s * 8 + 4, 32'(m_flag[s]));
        push_exp({sn, "_almost"}, s * 8 + 5, 32'(m_alm[s]));
        push_exp({sn, "_level"},  s * 8 + 6, 32'(m_lvl[s]));
      end
      if (!rst_n || flush) begin
        n_bin[s]  = 4'd0;
        n_s0[s]   = 4'd0;
        n_s1[s]   = 4'd0;
        n_lvl[s]  = 4'd0;
        n_flag[s] = (s == 1);
        n_alm[s]  = (s == 1);
      end else begin
        n_bin[s] = m_bin[s] + 4'(a[s]);
        rb       = g2b(m_s1[s]);
        if (s == 0) begin
          n_lvl[s]  = n_bin[s] - rb;
          n_flag[s] = (n_lvl[s] == 4'd8);
          n_alm[s]  = (n_lvl[s] >= 4'd6);
        end else begin
          n_lvl[s]  = rb - n_bin[s];
          n_flag[s] = (n_lvl[s] == 4'd0);
          n_alm[s]  = (n_lvl[s] <= 4'd2);
        end
        n_s1[s] = m_s0[s];
        n_s0[s] = rmt[s];
      end
    end
    @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      m_adv[s]  = (n_bin[s] != m_bin[s]);
      m_bin[s]  = n_bin[s];
      m_s0[s]   = n_s0[s];
      m_s1[s]   = n_s1[s];
      m_lvl[s]  = n_lvl[s];
      m_flag[s] = n_flag[s];
      m_alm[s]  = n_alm[s];
    end
    if (step) begin
      push_exp("wr_gray_step", 7, m_adv[0] ? 32'd1 : 32'd0);
      push_exp("rd_gray_step", 15, m_adv[1] ? 32'd1 : 32'd0);
    end
  endtask

  logic [3:0] gseq [9];
  int         l;

  initial begin
    gseq = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC};
    rst_n = 1'b0; flush = 1'b0; loop_en = 1'b0; inc = 2'b00;
    wr_rmt_drv = 4'h0; rd_rmt_drv = 4'h0;
    m_flag[0] = 1'b0; m_flag[1] = 1'b0;
    cycle(0, 0);

    // Reset values on both sides.
    push_exp("t1_wr_bin", 2, 0);    push_exp("t1_wr_gray", 3, 0);
    push_exp("t1_wr_flag", 4, 0);   push_exp("t1_wr_almost", 5, 0);
    push_exp("t1_wr_level", 6, 0);  push_exp("t1_rd_bin", 10, 0);
    push_exp("t1_rd_gray", 11, 0);  push_exp("t1_rd_flag", 12, 1);
    push_exp("t1_rd_almost", 13, 1); push_exp("t1_rd_level", 14, 0);
    cycle(1, 0);

    // Fill the write side against a stalled remote pointer.
    rst_n = 1'b1;
    inc   = 2'b01;
    for (int k = 0; k < 10; k++) begin
      l = (k > 8) ? 8 : k;
      push_exp("t2_gray", 3, 32'(gseq[l]));
      push_exp("t2_acc", 0, 32'(k < 8));
      push_exp("t2_flag", 4, 32'(k >= 8));
      push_exp("t2_almost", 5, 32'(l >= 6));
      push_exp("t2_level", 6, 32'(l));
      cycle(1, 0);
    end

    // Remote read of one entry reaches the flag after the two sync stages.
    inc        = 2'b00;
    wr_rmt_drv = 4'h1;
    for (int j = 0; j < 5; j++) begin
      if (j >= 3) inc = 2'b01;
      push_exp("t3_flag", 4, 32'(j != 3));
      push_exp("t3_level", 6, (j == 3) ? 32'd7 : 32'd8);
      push_exp("t3_acc", 0, 32'(j == 3));
      cycle(1, 0);
    end

    // Read side drains eight entries, then refuses a ninth pop.
    inc        = 2'b00;
    rd_rmt_drv = 4'hC;
    for (int j = 0; j < 12; j++) begin
      if (j >= 3) inc = 2'b10;
      l = (j < 3) ? 0 : 11 - j;
      push_exp("t5_flag", 12, 32'((j < 3) || (j == 11)));
      push_exp("t5_level", 14, 32'(l));
      push_exp("t5_almost", 13, 32'((j < 3) || (j >= 9)));
      push_exp("t5_acc", 8, 32'((j >= 3) && (j < 11)));
      cycle(1, 0);
    end

    // Looped-back pair under random traffic; pointers wrap several times.
    inc   = 2'b00;
    flush = 1'b1;
    cycle(1, 0);
    flush   = 1'b0;
    loop_en = 1'b1;
    cycle(1, 0);
    for (int k = 0; k < 100; k++) begin
      inc = {1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0)};
      cycle(1, 1);
    end

    // Flush, then reset, with a push request pending at bin_ptr=5.
    inc        = 2'b00;
    loop_en    = 1'b0;
    wr_rmt_drv = 4'h0;
    rd_rmt_drv = 4'h0;
    flush      = 1'b1;
    cycle(1, 0);
    flush = 1'b0;
    inc   = 2'b01;
    repeat (5) cycle(1, 0);
    flush = 1'b1;
    push_exp("t6_pre_bin", 2, 5);
    push_exp("t6_pre_acc", 0, 1);
    cycle(1, 0);
    flush = 1'b0;
    rst_n = 1'b0;
    push_exp("t6_flush_bin", 2, 0);
    push_exp("t6_flush_gray", 3, 0);
    push_exp("t6_flush_level", 6, 0);
    cycle(1, 0);
    rst_n = 1'b1;
    push_exp("t6_rst_bin", 2, 0);
    push_exp("t6_rst_flag", 4, 0);
    cycle(1, 0);
    inc = 2'b00;
    push_exp("t6_resume_bin", 2, 1);
    push_exp("t6_resume_gray", 3, 1);
    push_exp("t6_resume_level", 6, 1);
    cycle(1, 0);

    repeat (3) @(negedge clk);
    #1;
    if (sbq.size() != 0) begin
      $display("FAIL drain: got %0d pending, expected 0", sbq.size());
      n_total++;
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
